// File: rtl/lcd_word_scheduler.sv
// Round-robin scheduler that serialises words from two requesters onto the
// shared LCD character driver and tracks each write through the driver's busy/idle cycle.
module lcd_word_scheduler #(
   parameter int unsigned ACK_TIMEOUT  = 1000,
   parameter int unsigned DONE_TIMEOUT = 5000000,
   parameter int unsigned CNT_W        = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid_a,
   input  logic [31:0] req_data_a,
   input  logic        req_cd_a,
   output logic        req_ready_a,
   output logic        done_a,
   output logic        err_a,
   input  logic        req_valid_b,
   input  logic [31:0] req_data_b,
   input  logic        req_cd_b,
   output logic        req_ready_b,
   output logic        done_b,
   output logic        err_b,
   output logic [31:0] lcd_data,
   output logic        lcd_select_cd,
   output logic        lcd_enable_writing,
   input  logic        lcd_available,
   output logic        busy,
   output logic        owner
);

   localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] DONE_LAST = CNT_W'(DONE_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_BUSY,
      S_WAIT_DONE
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      data_q, data_d;
   logic             cd_q, cd_d;
   logic             strobe_q, strobe_d;
   logic             rdy_a_q, rdy_a_d, rdy_b_q, rdy_b_d;
   logic             done_a_q, done_a_d, done_b_q, done_b_d;
   logic             err_a_q, err_a_d, err_b_q, err_b_d;
   logic             busy_q, busy_d;
   logic             owner_q, owner_d;
   logic             grant_b;
   logic             accept;

   // On a tie the requester that did not hold the last grant wins.
   assign grant_b = req_valid_b && (!req_valid_a || !owner_q);
   assign accept  = lcd_available && (req_valid_a || req_valid_b);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         data_q   <= '0;
         cd_q     <= 1'b1;
         strobe_q <= 1'b0;
         rdy_a_q  <= 1'b0;
         rdy_b_q  <= 1'b0;
         done_a_q <= 1'b0;
         done_b_q <= 1'b0;
         err_a_q  <= 1'b0;
         err_b_q  <= 1'b0;
         busy_q   <= 1'b0;
         owner_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         data_q   <= data_d;
         cd_q     <= cd_d;
         strobe_q <= strobe_d;
         rdy_a_q  <= rdy_a_d;
         rdy_b_q  <= rdy_b_d;
         done_a_q <= done_a_d;
         done_b_q <= done_b_d;
         err_a_q  <= err_a_d;
         err_b_q  <= err_b_d;
         busy_q   <= busy_d;
         owner_q  <= owner_d;
      end
   end

   // Next-state logic; pulses are computed one edge early so the registered
   // outputs line up with ISSUE (ready/strobe) and the first IDLE cycle (done/err).
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      data_d   = data_q;
      cd_d     = cd_q;
      owner_d  = owner_q;
      strobe_d = 1'b0;
      rdy_a_d  = 1'b0;
      rdy_b_d  = 1'b0;
      done_a_d = 1'b0;
      done_b_d = 1'b0;
      err_a_d  = 1'b0;
      err_b_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               data_d   = grant_b ? req_data_b : req_data_a;
               cd_d     = grant_b ? req_cd_b : req_cd_a;
               owner_d  = grant_b;
               strobe_d = 1'b1;
               rdy_a_d  = !grant_b;
               rdy_b_d  = grant_b;
               state_d  = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_d   = '0;
            state_d = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (!lcd_available) begin
               cnt_d   = '0;
               state_d = S_WAIT_DONE;
            end else if (cnt_q == ACK_LAST) begin
               err_a_d = !owner_q;
               err_b_d = owner_q;
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_WAIT_DONE: begin
            if (lcd_available) begin
               done_a_d = !owner_q;
               done_b_d = owner_q;
               cnt_d    = '0;
               state_d  = S_IDLE;
            end else if (cnt_q == DONE_LAST) begin
               err_a_d = !owner_q;
               err_b_d = owner_q;
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   assign req_ready_a        = rdy_a_q;
   assign req_ready_b        = rdy_b_q;
   assign done_a             = done_a_q;
   assign done_b             = done_b_q;
   assign err_a              = err_a_q;
   assign err_b              = err_b_q;
   assign lcd_data           = data_q;
   assign lcd_select_cd      = cd_q;
   assign lcd_enable_writing = strobe_q;
   assign busy               = busy_q;
   assign owner              = owner_q;

endmodule

// File: doc/lcd_word_scheduler.md
Name: lcd_word_scheduler

Overview:
- Arbitrates and sequences access to the shared LCD character driver, which accepts a 32-bit four-character word, a command/data select and a one-cycle write strobe, and reports idle on its available flag.
- Two independent requesters (A, B) submit words through a valid/ready handshake.
- The scheduler grants them round-robin and issues one write at a time to the driver.
- It tracks the driver's busy/idle cycle, returns per-requester done or error pulses, and times out on a stuck driver.

Parameters:
- ACK_TIMEOUT, 1000: cycles after the strobe within which lcd_available must fall; otherwise the write is an error.
- DONE_TIMEOUT, 5000000: cycles (100 ms at 50 MHz) within which lcd_available must return high; otherwise the write is an error.
- CNT_W, 32: timeout counter width; must hold max(ACK_TIMEOUT, DONE_TIMEOUT).

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- rst  in  1  asynchronous, active-high reset
- req_valid_a  in  1  requester A has a word pending
- req_data_a  in  32  A's word, MSB = first character
- req_cd_a  in  1  A's select: 1 = data, 0 = command
- req_ready_a  out  1  one-cycle pulse: A's word accepted
- done_a  out  1  one-cycle pulse: A's write completed
- err_a  out  1  one-cycle pulse: A's write timed out
- req_valid_b, req_data_b, req_cd_b, req_ready_b, done_b, err_b: same as A, for requester B
- lcd_data  out  32  word to driver
- lcd_select_cd  out  1  select to driver
- lcd_enable_writing  out  1  write strobe to driver
- lcd_available  in  1  driver idle flag
- busy  out  1  high whenever state != IDLE
- owner  out  1  current or last grant: 0 = A, 1 = B

Behaviour:
- All outputs are registered. Reset values: lcd_data = 0, lcd_select_cd = 1, lcd_enable_writing = 0, all ready/done/err = 0, busy = 0, owner = 1 (so A wins the first tie), state = IDLE, counter = 0.
- Asserting rst at any time, including mid-write, forces these values immediately. No pulse is emitted for the aborted write.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - Acceptance on a clock edge requires lcd_available = 1 and at least one valid.
  - Only A valid: A wins. Only B valid: B wins. Both valid: the requester not equal to owner wins.
  - On acceptance: latch the winner's data and cd into lcd_data and lcd_select_cd, set owner, go to ISSUE.
  - No acceptance while lcd_available = 0.
- ISSUE (exactly one cycle):
  - lcd_enable_writing = 1 and the winner's req_ready pulse = 1 in this same cycle.
  - Counter cleared; next state WAIT_BUSY.
- Requester rule: hold valid, data and cd stable until ready is seen. Deassertion, or a new word, takes effect from the next cycle. No double accept is possible because the state has already left IDLE.
- WAIT_BUSY:
  - lcd_available = 0: go to WAIT_DONE, counter cleared.
  - Otherwise increment the counter. When counter = ACK_TIMEOUT-1, pulse the owner's err for one cycle and go to IDLE.
- WAIT_DONE:
  - lcd_available = 1: pulse the owner's done for one cycle and go to IDLE.
  - Otherwise increment the counter. At DONE_TIMEOUT-1, pulse err and go to IDLE.
- Timing: done and err are asserted during the first IDLE cycle. A new acceptance can occur on the edge ending that cycle, so back-to-back writes have a 1-cycle gap.
- lcd_data and lcd_select_cd stay stable from ISSUE until the next acceptance. They are never changed while busy.
- An error does not block the other requester. The next arbitration proceeds normally, with owner still updated to the errored requester.
- done and err are never both high. At most one of the A/B pulse outputs of each kind is high in any cycle.

Test Plan:
- Reset then A only: req_data_a = "HELL", cd = 1, driver drops available 2 cycles after the strobe and raises it 5 cycles later -> one ready_a and one strobe in the same cycle; lcd_data = 0x48454C4C; done_a exactly once; busy low afterwards.
- Both valid every cycle, driver responding -> grants strictly alternate A, B, A, B starting with A; lcd_data tracks the matching word; no duplicate ready.
- Driver never drops available, ACK_TIMEOUT = 8 -> err_a 8 cycles after WAIT_BUSY entry; no done_a; next B request is still served.
- Driver stays busy, DONE_TIMEOUT = 20 -> err_b pulse after 20 WAIT_DONE cycles; state returns to IDLE.
- Valid asserted while lcd_available = 0 in IDLE -> no ready and no strobe until available rises; acceptance on the first edge with available = 1.
- rst pulsed during WAIT_DONE -> outputs at reset values immediately; no done/err pulse; first post-reset tie goes to A.
